// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM arbiter: owner tags, default widths
// and the video fetch region bases.
package vram_arb_pkg;

   localparam int DEF_ADR_W = 16;
   localparam int DEF_DAT_W = 8;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_VID  = 2'd1,
      OWN_CPU  = 2'd2
   } own_e;

   localparam logic [15:0] CHARCELL_BASE = 16'h8000;
   localparam logic [15:0] GLYPH_BASE    = 16'h7000;

endpackage

// File: rtl/vram_arb_retpipe.sv
// Return path of the VRAM arbiter: two-stage owner tag pipe that steers the
// synchronous RAM read data to the video or CPU side and generates the acks.
module vram_arb_retpipe
   import vram_arb_pkg::*;
#(
   parameter int DAT_W = DEF_DAT_W
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  own_e             i_own,
   input  logic             i_cpu_rd,
   input  logic [DAT_W-1:0] i_ram_rdat,
   output logic [DAT_W-1:0] o_vid_dat,
   output logic             o_vid_ack,
   output logic [DAT_W-1:0] o_cpu_rdat,
   output logic             o_cpu_ack
);

   own_e             r_own_p1, r_own_p2;
   logic             r_rd_p1, r_rd_p2;
   logic             r_vid_ack, r_cpu_ack;
   logic [DAT_W-1:0] r_vid_dat, r_cpu_rdat;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_own_p1   <= OWN_NONE;
         r_own_p2   <= OWN_NONE;
         r_rd_p1    <= 1'b0;
         r_rd_p2    <= 1'b0;
         r_vid_ack  <= 1'b0;
         r_cpu_ack  <= 1'b0;
         r_vid_dat  <= '0;
         r_cpu_rdat <= '0;
      end else begin
         // p1: access on the RAM bus; p2: RAM read data valid
         r_own_p1  <= i_own;
         r_rd_p1   <= i_cpu_rd;
         r_own_p2  <= r_own_p1;
         r_rd_p2   <= r_rd_p1;
         r_vid_ack <= (r_own_p2 == OWN_VID);
         r_cpu_ack <= (r_own_p2 == OWN_CPU);
         if (r_own_p2 == OWN_VID)
            r_vid_dat <= i_ram_rdat;
         // a CPU write completes with an ack but leaves the read data untouched
         if ((r_own_p2 == OWN_CPU) && r_rd_p2)
            r_cpu_rdat <= i_ram_rdat;
      end
   end

   assign o_vid_dat  = r_vid_dat;
   assign o_vid_ack  = r_vid_ack;
   assign o_cpu_rdat = r_cpu_rdat;
   assign o_cpu_ack  = r_cpu_ack;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches have priority, the CPU is granted after
// at most CPU_MAX_WAIT lost edges. Define VRAM_ARB_STATS_EN for grant/stall statistics.
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int ADR_W        = DEF_ADR_W,
   parameter int DAT_W        = DEF_DAT_W,
   parameter int CPU_MAX_WAIT = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_vid_req,
   input  logic [ADR_W-1:0] i_vid_adr,
   output logic [DAT_W-1:0] o_vid_dat,
   output logic             o_vid_ack,
   output logic             o_vid_overrun,
   input  logic             i_cpu_req,
   input  logic             i_cpu_we,
   input  logic [ADR_W-1:0] i_cpu_adr,
   input  logic [DAT_W-1:0] i_cpu_wdat,
   output logic [DAT_W-1:0] o_cpu_rdat,
   output logic             o_cpu_ack,
   input  logic [DAT_W-1:0] i_ram_rdat,
`ifdef VRAM_ARB_STATS_EN
   output logic [31:0]      o_stat_vid_cnt,
   output logic [31:0]      o_stat_cpu_cnt,
   output logic [7:0]       o_stat_stall_max,
`endif
   output logic             o_ram_en,
   output logic             o_ram_we,
   output logic [ADR_W-1:0] o_ram_adr,
   output logic [DAT_W-1:0] o_ram_wdat
);

   localparam logic [7:0] MAX_WAIT = 8'(CPU_MAX_WAIT);

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == MAX_WAIT) ? v : v + 8'd1;
   endfunction

   logic             r_vpend_vld, r_vid_overrun, r_cpu_busy;
   logic [ADR_W-1:0] r_vpend_adr;
   logic [7:0]       r_wait_cnt;
   logic             r_ram_en, r_ram_we;
   logic [ADR_W-1:0] r_ram_adr;
   logic [DAT_W-1:0] r_ram_wdat;

   logic             w_v, w_c, w_starve, w_gnt_cpu, w_gnt_vid;
   logic             w_vpend_iss, w_skid, w_vpend_room, w_cpu_ack;
   logic [ADR_W-1:0] w_vid_adr;
   own_e             w_own;

   assign w_v          = i_vid_req | r_vpend_vld;
   assign w_c          = i_cpu_req & ~r_cpu_busy;
   assign w_starve     = (r_wait_cnt == MAX_WAIT);
   assign w_gnt_cpu    = w_c & (w_starve | ~w_v);
   assign w_gnt_vid    = ~w_gnt_cpu & w_v;
   assign w_vpend_iss  = w_gnt_vid & r_vpend_vld;
   assign w_vid_adr    = r_vpend_vld ? r_vpend_adr : i_vid_adr;
   // a new fetch not issued directly must go through the skid slot
   assign w_skid       = i_vid_req & (w_gnt_cpu | r_vpend_vld);
   assign w_vpend_room = ~r_vpend_vld | w_vpend_iss;

   always_comb begin
      w_own = OWN_NONE;
      if (w_gnt_cpu)
         w_own = OWN_CPU;
      else if (w_gnt_vid)
         w_own = OWN_VID;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_vpend_vld   <= 1'b0;
         r_vpend_adr   <= '0;
         r_vid_overrun <= 1'b0;
         r_wait_cnt    <= 8'd0;
         r_cpu_busy    <= 1'b0;
         r_ram_en      <= 1'b0;
         r_ram_we      <= 1'b0;
         r_ram_adr     <= '0;
         r_ram_wdat    <= '0;
      end else begin
         if (w_skid && w_vpend_room) begin
            r_vpend_vld <= 1'b1;
            r_vpend_adr <= i_vid_adr;
         end else if (w_vpend_iss) begin
            r_vpend_vld <= 1'b0;
         end
         if (w_skid && !w_vpend_room)
            r_vid_overrun <= 1'b1;

         if (!i_cpu_req || w_gnt_cpu)
            r_wait_cnt <= 8'd0;
         else if (w_c)
            r_wait_cnt <= sat_inc(r_wait_cnt);

         // busy drops one edge after the ack so a held cpu_req is not re-granted
         if (w_gnt_cpu)
            r_cpu_busy <= 1'b1;
         else if (w_cpu_ack)
            r_cpu_busy <= 1'b0;

         // p0: grant registered onto the RAM bus
         r_ram_en <= w_gnt_cpu | w_gnt_vid;
         r_ram_we <= w_gnt_cpu & i_cpu_we;
         if (w_gnt_cpu) begin
            r_ram_adr  <= i_cpu_adr;
            r_ram_wdat <= i_cpu_wdat;
         end else if (w_gnt_vid) begin
            r_ram_adr  <= w_vid_adr;
         end
      end
   end

   vram_arb_retpipe #(.DAT_W(DAT_W)) u_retpipe (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_own      (w_own),
      .i_cpu_rd   (w_gnt_cpu & ~i_cpu_we),
      .i_ram_rdat (i_ram_rdat),
      .o_vid_dat  (o_vid_dat),
      .o_vid_ack  (o_vid_ack),
      .o_cpu_rdat (o_cpu_rdat),
      .o_cpu_ack  (w_cpu_ack)
   );

`ifdef VRAM_ARB_STATS_EN
   logic [31:0] r_stat_vid_cnt, r_stat_cpu_cnt;
   logic [7:0]  r_stat_stall_max;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_stat_vid_cnt   <= 32'd0;
         r_stat_cpu_cnt   <= 32'd0;
         r_stat_stall_max <= 8'd0;
      end else begin
         r_stat_vid_cnt <= r_stat_vid_cnt + {31'd0, w_gnt_vid};
         r_stat_cpu_cnt <= r_stat_cpu_cnt + {31'd0, w_gnt_cpu};
         if (r_wait_cnt > r_stat_stall_max)
            r_stat_stall_max <= r_wait_cnt;
      end
   end

   assign o_stat_vid_cnt   = r_stat_vid_cnt;
   assign o_stat_cpu_cnt   = r_stat_cpu_cnt;
   assign o_stat_stall_max = r_stat_stall_max;
`endif

   assign o_cpu_ack     = w_cpu_ack;
   assign o_vid_overrun = r_vid_overrun;
   assign o_ram_en      = r_ram_en;
   assign o_ram_we      = r_ram_we;
   assign o_ram_adr     = r_ram_adr;
   assign o_ram_wdat    = r_ram_wdat;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed scenarios plus a randomized run checked
// against a queue-based arbitration model; a synchronous RAM is emulated here.
module tb_vram_arbiter;
   import vram_arb_pkg::*;

   localparam int MAXW = 3;
   localparam int NR   = 3000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
   logic [15:0] vid_adr = '0, cpu_adr = '0;
   logic [7:0]  cpu_wdat = '0;
   logic [7:0]  vid_dat, cpu_rdat, ram_rdat, ram_wdat;
   logic        vid_ack, vid_ovr, cpu_ack, ram_en, ram_we;
   logic [15:0] ram_adr;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mem [0:65535];
   int         ek [0:NR+3];
   logic [7:0] ed [0:NR+3];

   always #5 clk = ~clk;

   vram_arbiter #(.ADR_W(16), .DAT_W(8), .CPU_MAX_WAIT(MAXW)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_vid_req(vid_req), .i_vid_adr(vid_adr), .o_vid_dat(vid_dat),
      .o_vid_ack(vid_ack), .o_vid_overrun(vid_ovr),
      .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_adr(cpu_adr),
      .i_cpu_wdat(cpu_wdat), .o_cpu_rdat(cpu_rdat), .o_cpu_ack(cpu_ack),
      .i_ram_rdat(ram_rdat),
      .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_adr(ram_adr), .o_ram_wdat(ram_wdat)
   );

   // synchronous read-first RAM
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_adr] <= ram_wdat;
         ram_rdat <= mem[ram_adr];
      end
   end

   function automatic logic [7:0] pat(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic logic [15:0] stv_adr(input int k);
      if (k < 3) return 16'h8100 + 16'(k);
      if (k == 3) return 16'h0100;
      return 16'h8100 + 16'(k - 1);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      n_checks++;
      if ({ram_en, ram_we, ram_adr, ram_wdat} !== 26'd0) begin
         n_fail++; $display("FAIL reset_ram: got %h want 0", {ram_en, ram_we, ram_adr, ram_wdat});
      end
      n_checks++;
      if ({vid_ack, vid_ovr, vid_dat} !== 10'd0) begin
         n_fail++; $display("FAIL reset_vid: got %h want 0", {vid_ack, vid_ovr, vid_dat});
      end
      n_checks++;
      if ({cpu_ack, cpu_rdat} !== 9'd0) begin
         n_fail++; $display("FAIL reset_cpu: got %h want 0", {cpu_ack, cpu_rdat});
      end
      reset = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_cpu_read();
      int acks = 0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h1234;
      tick();
      n_checks++;
      if ({ram_en, ram_we, ram_adr} !== {2'b10, 16'h1234}) begin
         n_fail++; $display("FAIL cpu_rd_issue: got %h want %h", {ram_en, ram_we, ram_adr}, {2'b10, 16'h1234});
      end
      tick();
      n_checks++;
      if (cpu_ack !== 1'b0) begin
         n_fail++; $display("FAIL cpu_rd_early_ack: got %b want 0", cpu_ack);
      end
      tick();
      n_checks++;
      if ({cpu_ack, cpu_rdat} !== {1'b1, 8'hA5}) begin
         n_fail++; $display("FAIL cpu_rd_ack: got %h want %h", {cpu_ack, cpu_rdat}, {1'b1, 8'hA5});
      end
      cpu_req = 1'b0;
      repeat (5) begin
         tick();
         if (cpu_ack) acks++;
      end
      n_checks++;
      if (acks != 0) begin
         n_fail++; $display("FAIL cpu_rd_extra_ack: got %0d want 0", acks);
      end
   endtask

   task automatic test_video_stream();
      for (int k = 0; k < 12; k++) begin
         vid_req = (k < 8);
         vid_adr = CHARCELL_BASE + 16'(k);
         tick();
         n_checks++;
         if (ram_en !== (k < 8)) begin
            n_fail++; $display("FAIL vstream_en k=%0d: got %b want %b", k, ram_en, (k < 8));
         end
         if (k < 8) begin
            n_checks++;
            if (ram_adr !== CHARCELL_BASE + 16'(k)) begin
               n_fail++; $display("FAIL vstream_adr k=%0d: got %h want %h", k, ram_adr, CHARCELL_BASE + 16'(k));
            end
         end
         n_checks++;
         if (vid_ack !== (k >= 2 && k < 10)) begin
            n_fail++; $display("FAIL vstream_ack k=%0d: got %b want %b", k, vid_ack, (k >= 2 && k < 10));
         end
         if (k >= 2 && k < 10) begin
            n_checks++;
            if (vid_dat !== pat(CHARCELL_BASE + 16'(k - 2))) begin
               n_fail++; $display("FAIL vstream_dat k=%0d: got %h want %h", k, vid_dat, pat(CHARCELL_BASE + 16'(k - 2)));
            end
         end
      end
      vid_req = 1'b0;
   endtask

   task automatic test_starvation();
      logic va;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 16'h0100; cpu_wdat = 8'h3C;
      for (int k = 0; k < 12; k++) begin
         vid_req = (k <= 7);
         vid_adr = 16'h8100 + 16'(k);
         tick();
         n_checks++;
         if (ram_en !== (k <= 8)) begin
            n_fail++; $display("FAIL starve_en k=%0d: got %b want %b", k, ram_en, (k <= 8));
         end
         if (k <= 8) begin
            n_checks++;
            if ({ram_we, ram_adr} !== {(k == 3), stv_adr(k)}) begin
               n_fail++; $display("FAIL starve_grant k=%0d: got %h want %h", k, {ram_we, ram_adr}, {(k == 3), stv_adr(k)});
            end
         end
         if (k == 3) begin
            n_checks++;
            if (ram_wdat !== 8'h3C) begin
               n_fail++; $display("FAIL starve_wdat: got %h want 3c", ram_wdat);
            end
         end
         n_checks++;
         if (cpu_ack !== (k == 5)) begin
            n_fail++; $display("FAIL starve_cpu_ack k=%0d: got %b want %b", k, cpu_ack, (k == 5));
         end
         va = (k >= 2 && k <= 10 && k != 5);
         n_checks++;
         if (vid_ack !== va) begin
            n_fail++; $display("FAIL starve_vid_ack k=%0d: got %b want %b", k, vid_ack, va);
         end
         if (va) begin
            n_checks++;
            if (vid_dat !== pat(stv_adr(k - 2))) begin
               n_fail++; $display("FAIL starve_vid_dat k=%0d: got %h want %h", k, vid_dat, pat(stv_adr(k - 2)));
            end
         end
         n_checks++;
         if (vid_ovr !== 1'b0) begin
            n_fail++; $display("FAIL starve_overrun k=%0d: got %b want 0", k, vid_ovr);
         end
         if (k == 5) cpu_req = 1'b0;
      end
      n_checks++;
      if (mem[16'h0100] !== 8'h3C) begin
         n_fail++; $display("FAIL starve_ram_write: got %h want 3c", mem[16'h0100]);
      end
      cpu_we = 1'b0;
   endtask

   task automatic test_idle();
      int bad = 0;
      vid_req = 1'b0; cpu_req = 1'b0;
      repeat (20) begin
         tick();
         if (ram_en !== 1'b0 || ram_we !== 1'b0 || vid_ack !== 1'b0 || cpu_ack !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++; $display("FAIL idle_quiet: got %0d active cycles want 0", bad);
      end
      // counter must start from zero: CPU wins on the 4th contending edge
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h1234;
      for (int k = 0; k < 6; k++) begin
         vid_req = 1'b1;
         vid_adr = CHARCELL_BASE + 16'(k);
         tick();
         n_checks++;
         if ((ram_en && ram_adr == 16'h1234) !== (k == 3)) begin
            n_fail++; $display("FAIL idle_wait_start k=%0d: got %h want cpu grant only at k=3", k, ram_adr);
         end
         if (cpu_ack) cpu_req = 1'b0;
      end
      vid_req = 1'b0; cpu_req = 1'b0;
      repeat (5) tick();
   endtask

   task automatic test_overrun();
      int nv = 0;
      int j;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h1234;
      for (int k = 0; k < 20; k++) begin
         vid_req = (k <= 11);
         vid_adr = 16'h8200 + 16'(k);
         tick();
         n_checks++;
         if (vid_ovr !== (k >= 10)) begin
            n_fail++; $display("FAIL overrun_flag k=%0d: got %b want %b", k, vid_ovr, (k >= 10));
         end
         if (vid_ack) begin
            j = (nv < 10) ? nv : nv + 1;
            n_checks++;
            if (nv >= 11 || vid_dat !== pat(16'h8200 + 16'(j))) begin
               n_fail++; $display("FAIL overrun_vid_dat n=%0d: got %h want %h", nv, vid_dat, pat(16'h8200 + 16'(j)));
            end
            nv++;
         end
         if (cpu_ack && k == 5) cpu_adr = 16'h1235;
         else if (cpu_ack) cpu_req = 1'b0;
      end
      n_checks++;
      if (nv != 11) begin
         n_fail++; $display("FAIL overrun_ack_count: got %0d want 11", nv);
      end
      vid_req = 1'b0; cpu_req = 1'b0;
   endtask

   task automatic test_reset_midflight();
      int bad = 0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h1234;
      tick();
      n_checks++;
      if (ram_en !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_grant: got %b want 1", ram_en);
      end
      tick();
      reset = 1'b1;
      #1;
      n_checks++;
      if ({ram_en, ram_we, ram_adr, ram_wdat, vid_ovr, vid_ack, cpu_ack, vid_dat, cpu_rdat} !== 45'd0) begin
         n_fail++; $display("FAIL rstmid_outputs: got %h want 0",
                            {ram_en, ram_we, ram_adr, ram_wdat, vid_ovr, vid_ack, cpu_ack, vid_dat, cpu_rdat});
      end
      repeat (3) begin
         tick();
         if (cpu_ack !== 1'b0 || ram_en !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++; $display("FAIL rstmid_no_ack: got %0d active cycles want 0", bad);
      end
      reset = 1'b0;
      tick();
      n_checks++;
      if ({ram_en, ram_adr} !== {1'b1, 16'h1234}) begin
         n_fail++; $display("FAIL rstmid_regrant: got %h want %h", {ram_en, ram_adr}, {1'b1, 16'h1234});
      end
      tick();
      n_checks++;
      if (cpu_ack !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_early_ack: got %b want 0", cpu_ack);
      end
      tick();
      n_checks++;
      if ({cpu_ack, cpu_rdat} !== {1'b1, 8'hA5}) begin
         n_fail++; $display("FAIL rstmid_ack: got %h want %h", {cpu_ack, cpu_rdat}, {1'b1, 8'hA5});
      end
      cpu_req = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_random();
      logic [15:0] vq [$];
      logic [15:0] q  [$];
      logic [7:0]  sh [int];
      logic [15:0] gadr;
      logic [7:0]  m_vdat = 8'h00, m_cdat = 8'h00;
      int  m_wait = 0;
      bit  m_busy = 1'b0, m_ovr = 1'b0, m_ack_prev = 1'b0, c_act = 1'b0;
      bit  elig, gc, gv, gwe;
      for (int i = 0; i < NR + 4; i++) begin ek[i] = 0; ed[i] = 8'h00; end
      vid_req = 1'b0; cpu_req = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int e = 0; e < NR; e++) begin
         if (!c_act) begin
            if ($urandom_range(0, 2) == 0) begin
               c_act    = 1'b1;
               cpu_req  = 1'b1;
               cpu_we   = $urandom_range(0, 1) == 1;
               cpu_adr  = ($urandom_range(0, 1) == 1 ? GLYPH_BASE : 16'h0200) + 16'($urandom_range(0, 15));
               cpu_wdat = 8'($urandom);
            end else begin
               cpu_req = 1'b0;
            end
         end
         vid_req = $urandom_range(0, 1) == 1;
         vid_adr = ($urandom_range(0, 1) == 1 ? CHARCELL_BASE : GLYPH_BASE) + 16'($urandom_range(0, 15));

         q = vq;
         if (vid_req) q.push_back(vid_adr);
         elig = cpu_req && !m_busy;
         gc   = elig && (m_wait == MAXW || q.size() == 0);
         gv   = !gc && q.size() > 0;
         gwe  = gc && cpu_we;
         gadr = 16'h0000;
         if (gc) begin
            gadr = cpu_adr;
            ek[e+2] = cpu_we ? 2 : 3;
            ed[e+2] = sh.exists(int'(gadr)) ? sh[int'(gadr)] : pat(gadr);
            if (cpu_we) sh[int'(gadr)] = cpu_wdat;
         end else if (gv) begin
            gadr = q.pop_front();
            ek[e+2] = 1;
            ed[e+2] = sh.exists(int'(gadr)) ? sh[int'(gadr)] : pat(gadr);
         end
         if (q.size() > 1) begin
            m_ovr = 1'b1;
            q.delete(1);
         end
         vq = q;
         if (!cpu_req || gc) m_wait = 0;
         else if (elig && m_wait < MAXW) m_wait++;
         if (gc) m_busy = 1'b1;
         else if (m_ack_prev) m_busy = 1'b0;

         tick();

         if (ek[e] == 1) m_vdat = ed[e];
         if (ek[e] == 3) m_cdat = ed[e];
         n_checks++;
         if ({ram_en, ram_we} !== {gc | gv, gwe}) begin
            n_fail++; $display("FAIL rand_en_we e=%0d: got %b%b want %b%b", e, ram_en, ram_we, gc | gv, gwe);
         end
         if (gc | gv) begin
            n_checks++;
            if (ram_adr !== gadr) begin
               n_fail++; $display("FAIL rand_adr e=%0d: got %h want %h", e, ram_adr, gadr);
            end
         end
         if (gwe) begin
            n_checks++;
            if (ram_wdat !== cpu_wdat) begin
               n_fail++; $display("FAIL rand_wdat e=%0d: got %h want %h", e, ram_wdat, cpu_wdat);
            end
         end
         n_checks++;
         if ({vid_ack, cpu_ack} !== {ek[e] == 1, ek[e] >= 2}) begin
            n_fail++; $display("FAIL rand_acks e=%0d: got %b%b want %b%b", e, vid_ack, cpu_ack, ek[e] == 1, ek[e] >= 2);
         end
         n_checks++;
         if ({vid_dat, cpu_rdat} !== {m_vdat, m_cdat}) begin
            n_fail++; $display("FAIL rand_data e=%0d: got %h want %h", e, {vid_dat, cpu_rdat}, {m_vdat, m_cdat});
         end
         n_checks++;
         if (vid_ovr !== m_ovr) begin
            n_fail++; $display("FAIL rand_overrun e=%0d: got %b want %b", e, vid_ovr, m_ovr);
         end
         m_ack_prev = (ek[e] >= 2);
         if (m_ack_prev) c_act = 1'b0;
      end
      vid_req = 1'b0; cpu_req = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = pat(i[15:0]);
      mem[16'h1234] = 8'hA5;
      test_reset();
      test_cpu_read();
      repeat (3) tick();
      test_video_stream();
      repeat (3) tick();
      test_starvation();
      repeat (3) tick();
      test_idle();
      test_overrun();
      repeat (3) tick();
      test_reset_midflight();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port 64 KiB VRAM between the video controller's fetch engine and the CPU bus.
- Fetches are charcell index reads at 0x8000+ and glyph row reads at 0x7000–0x7FFF.
- Video fetches have priority. The CPU is guaranteed a slot within a bounded wait.
- Registered, pipelined: one RAM access issued per clock, read data returned with a fixed 2-cycle latency.

Parameters:
- ADR_W, 16, VRAM address width
- DAT_W, 8, VRAM data width
- CPU_MAX_WAIT, 8, max consecutive cycles a pending CPU request may lose arbitration; legal range 1..255

Ports:
- clk  in  1  arbitration/RAM clock (pixel clock domain)
- reset  in  1  reset, asynchronous, active-high
- vid_req  in  1  single-cycle fetch strobe from video controller; fire-and-forget, never held
- vid_adr  in  ADR_W  fetch address, valid with vid_req
- vid_dat  out  DAT_W  fetch read data
- vid_ack  out  1  one-cycle pulse, vid_dat valid
- vid_overrun  out  1  sticky error: video request dropped
- cpu_req  in  1  level request, held until cpu_ack
- cpu_we  in  1  1=write, 0=read; stable while cpu_req
- cpu_adr  in  ADR_W  CPU address; stable while cpu_req
- cpu_wdat  in  DAT_W  CPU write data
- cpu_rdat  out  DAT_W  CPU read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle completion pulse (read and write)
- ram_en  out  1  RAM access enable
- ram_we  out  1  RAM write enable
- ram_adr  out  ADR_W  RAM address
- ram_wdat  out  DAT_W  RAM write data
- ram_rdat  in  DAT_W  RAM read data, valid one clock after the access edge (synchronous RAM)

Behaviour:
- Reset values: all outputs 0; internal pending, busy, starvation counter and tag pipe cleared.
- Reset mid-operation: in-flight accesses are discarded and no ack is generated. The CPU must re-assert or keep cpu_req, which is re-arbitrated from scratch.
- Arbitration runs every posedge. Candidates are:
  - V: vid_req, or the 1-deep video skid register vpend.
  - C: cpu_req && !cpu_busy.
- Decision at each edge:
  - starve = (wait_cnt == CPU_MAX_WAIT).
  - If C && (starve || !V): grant CPU.
  - Else if V: grant video; vpend has priority over a new vid_req.
  - Else idle: ram_en=0, ram_we=0.
- Grant effect: ram_en/ram_adr/ram_we/ram_wdat are registered at the grant edge. ram_we=1 only for a CPU write.
- Owner tag: a 2-stage shift register with values NONE/VID/CPU.
  - Stage 2 owner VID: vid_dat<=ram_rdat and vid_ack=1.
  - Stage 2 owner CPU: cpu_rdat<=ram_rdat (read) or held (write), and cpu_ack=1.
- Latency: request sampled at edge E0 → ack and data valid after E2. Back-to-back video grants sustain 1 access/clock.
- cpu_busy is set on CPU grant and cleared on cpu_ack, so at most one CPU access is in flight.
- The cycle after cpu_ack the CPU must drop or change cpu_req. cpu_busy is low that cycle, so the next request is a new transaction.
- Video skid:
  - If a vid_req arrives on an edge where the CPU is granted, or where vpend is being issued, the request is latched into vpend. That fetch then takes latency 3.
  - If vpend is already full and not issued at that edge, the new request is dropped and vid_overrun is set. vid_overrun clears only on reset.
- Starvation counter wait_cnt (8 bit):
  - Increments each edge C is true and not granted.
  - Resets to 0 on CPU grant or when cpu_req=0.
  - Saturates at CPU_MAX_WAIT.
- Simultaneous vid_req with starve: CPU wins, video goes to vpend, no overrun unless vpend is already occupied.

Optional Feature:
- VRAM_ARB_STATS_EN defined: adds outputs stat_vid_cnt[31:0] (video grants), stat_cpu_cnt[31:0] (CPU grants) and stat_stall_max[7:0] (peak wait_cnt).
  - All wrap modulo 2^32 or hold max, and clear on reset.
- VRAM_ARB_STATS_EN undefined: these ports and counters are absent; core behaviour is identical.

Decomposition:
- Package vram_arb_pkg:
  - Owner tag constants OWN_NONE=2'd0, OWN_VID=2'd1, OWN_CPU=2'd2.
  - Default widths ADR_W/DAT_W.
  - Region bases CHARCELL_BASE=16'h8000 and GLYPH_BASE=16'h7000, for bench address generation.
- One sub-module: vram_arb_retpipe, the 2-stage owner-tag pipe plus vid/cpu return-data registers and ack generation. The top holds the arbiter, skid and starvation logic.

Test Plan:
- CPU read, no video: cpu_req=1, cpu_adr=16'h1234, RAM holds 8'hA5 → ram_en high after E0, cpu_ack pulse and cpu_rdat=8'hA5 after E2, exactly one ack.
- Video stream 8 consecutive vid_req at 0x8000..0x8007 → 8 ram_en cycles back-to-back, vid_ack on 8 consecutive cycles starting 2 cycles after the first request, data in order.
- Starvation, CPU_MAX_WAIT=3, vid_req every cycle and cpu_req write 0x0100=8'h3C → CPU granted on 4th contending edge with ram_we=1, the colliding fetch is served from vpend with latency 3, vid_overrun stays 0.
- Overrun: force CPU grant with vpend already full and a new vid_req on the same edge → vid_overrun=1 and stays set, dropped fetch never acked.
- Reset mid-flight: assert reset 1 cycle after a CPU read grant → no cpu_ack, all outputs 0. After release the held cpu_req completes normally with latency 2.
- Idle: no requests for 20 cycles → ram_en=0, ram_we=0, no acks, wait_cnt=0.
